// File: rtl/csa_resolver_pkg.sv
// Shared MAC package: geometry helpers for the carry-save resolver.
package csa_resolver_pkg;

    function automatic int calc_nstage(int width, int chunk);
        return (width + chunk) / chunk;
    endfunction

    function automatic int calc_res_w(int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Handshake bundle between the CSA stage, the resolver and its consumer.
interface csa_resolver_if
    import csa_resolver_pkg::*;
#(
    parameter int WIDTH = 10
);
    localparam int RES_W = calc_res_w(WIDTH);

    logic [WIDTH-1:0] in_sum;
    logic [WIDTH:0]   in_carry;
    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] out_result;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_sum, in_carry, in_valid, out_ready,
        input  in_ready, out_result, out_valid
    );

    modport slave (
        input  in_sum, in_carry, in_valid, out_ready,
        output in_ready, out_result, out_valid
    );

endinterface

// File: rtl/csa_resolve_stage.sv
// One CHUNK-bit ripple slice of the resolver plus its pipeline register.
module csa_resolve_stage #(
    parameter int CHUNK = 4,
    parameter int PW    = 12,
    parameter int K     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          prev_valid,
    input  logic [PW-1:0] prev_a,
    input  logic [PW-1:0] prev_b,
    input  logic          prev_c,
    output logic          valid,
    output logic [PW-1:0] a,
    output logic [PW-1:0] b,
    output logic          c
);
    localparam int LO = K * CHUNK;

    logic [CHUNK:0]  slice_sum;
    logic [PW-1:0]   a_next;
    logic [PW-1:0]   b_next;

    // a carries resolved low bits plus the untouched upper sum slices;
    // b keeps only the still-unresolved upper carry slices.
    always_comb begin
        slice_sum = {1'b0, prev_a[LO +: CHUNK]}
                  + {1'b0, prev_b[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, prev_c};
        a_next = prev_a;
        a_next[LO +: CHUNK] = slice_sum[CHUNK-1:0];
        b_next = prev_b;
        b_next[LO +: CHUNK] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            c     <= 1'b0;
        end else if (load) begin
            valid <= prev_valid;
            a     <= a_next;
            b     <= b_next;
            c     <= slice_sum[CHUNK];
        end
    end

endmodule

// File: rtl/csa_resolver.sv
// Pipelined carry-propagate adder resolving CSA (sum, carry) pairs.
module csa_resolver
    import csa_resolver_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CHUNK = 4
) (
    input logic     clk,
    input logic     rst,
    csa_resolver_if.slave bus
);
    localparam int NSTAGE = calc_nstage(WIDTH, CHUNK);
    localparam int PW     = NSTAGE * CHUNK;
    localparam int RES_W  = calc_res_w(WIDTH);

    logic [PW-1:0]     a_s [NSTAGE];
    logic [PW-1:0]     b_s [NSTAGE];
    logic [NSTAGE-1:0] valid_s;
    logic [NSTAGE-1:0] c_s;
    logic [NSTAGE:0]   load;
    logic              unused_b;

    // A stage may load when empty or when its successor drains it.
    always_comb begin
        load = '0;
        load[NSTAGE] = bus.out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            load[k] = !valid_s[k] || load[k+1];
        end
    end

    assign bus.in_ready = !rst && load[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            csa_resolve_stage #(
                .CHUNK(CHUNK), .PW(PW), .K(k)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .load       (load[k]),
                .prev_valid (bus.in_valid),
                .prev_a     (PW'(bus.in_sum)),
                .prev_b     (PW'(bus.in_carry)),
                .prev_c     (1'b0),
                .valid      (valid_s[k]),
                .a          (a_s[k]),
                .b          (b_s[k]),
                .c          (c_s[k])
            );
        end else begin : g_next
            csa_resolve_stage #(
                .CHUNK(CHUNK), .PW(PW), .K(k)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .load       (load[k]),
                .prev_valid (valid_s[k-1]),
                .prev_a     (a_s[k-1]),
                .prev_b     (b_s[k-1]),
                .prev_c     (c_s[k-1]),
                .valid      (valid_s[k]),
                .a          (a_s[k]),
                .b          (b_s[k]),
                .c          (c_s[k])
            );
        end
    end

    // Last-stage b is all zeros by construction.
    assign unused_b = |b_s[NSTAGE-1];

    assign bus.out_valid  = valid_s[NSTAGE-1];
    assign bus.out_result = RES_W'({c_s[NSTAGE-1], a_s[NSTAGE-1]});

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver with directed and random vectors.
module tb_csa_resolver;
    import csa_resolver_pkg::*;

    localparam int WIDTH = 10;
    localparam int RES_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    csa_resolver_if #(.WIDTH(WIDTH)) bus ();

    csa_resolver #(.WIDTH(WIDTH), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int outs = 0;
    int stalls = 0;
    logic [RES_W-1:0] q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out actual=%h required=none",
                         bus.out_result);
            end else begin
                chk("result", 32'(bus.out_result), 32'(q[0]));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    outs++;
                end
            end
        end
    end

    task automatic put(input logic [9:0] s, input logic [10:0] c,
                       input logic [11:0] e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_sum = s;
        bus.in_carry = c;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (bus.in_ready) begin
            q.push_back(e);
        end else begin
            total++;
            bad++;
            $display("FAIL put_timeout actual=stalled required=accept");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        chk(name, 32'(lat), 32'd3);
        @(negedge clk);
        chk({name, "_pulse"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [9:0]  bp_s [3] = '{10'h155, 10'h200, 10'h0AB};
    logic [10:0] bp_c [3] = '{11'h2AA, 11'h600, 11'h0CD};
    logic [11:0] bp_e [3] = '{12'h3FF, 12'h800, 12'h178};

    initial begin
        int k;
        int outs0;
        logic [9:0]  s;
        logic [10:0] c;

        bus.in_valid = 1'b1;
        bus.in_sum = 10'h3FF;
        bus.in_carry = 11'h7FE;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_result", 32'(bus.out_result), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        put(10'h3FF, 11'h7FE, 12'hBFD);
        check_latency("single_latency");

        put(10'h00F, 11'h001, 12'h010);
        put(10'h3FF, 11'h001, 12'h400);
        drain();

        stalls = 0;
        outs0 = outs;
        for (int i = 0; i < 100; i++) begin
            s = 10'($urandom);
            c = 11'($urandom);
            put(s, c, 12'(s) + 12'(c));
        end
        chk("stream_stalls", 32'(stalls), 32'd0);
        drain();
        chk("stream_count", 32'(outs - outs0), 32'd100);

        // Backpressure: capacity is one pair per stage.
        outs0 = outs;
        bus.out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum = bp_s[k < 3 ? k : 2];
            bus.in_carry = bp_c[k < 3 ? k : 2];
            @(negedge clk);
            if (i >= 3)
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.in_ready) begin
                q.push_back(bp_e[k < 3 ? k : 2]);
                k++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_accepts", 32'(k), 32'd3);
        put(10'h3FF, 11'h7FF, 12'hBFE);
        drain();
        chk("bp_outs", 32'(outs - outs0), 32'd4);

        outs0 = outs;
        put(10'h123, 11'h045, 12'h168);
        put(10'h0FF, 11'h101, 12'h200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        put(10'h001, 11'h002, 12'h003);
        check_latency("post_rst_latency");
        drain();
        chk("midrst_outs", 32'(outs - outs0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
